kvs_vs_regex_decision_join: RTL and testbench

- Downstream stage of the regex engine array.
- Pairs the in-order stream of 1-bit per-value match decisions with the per-value metadata (key/pointer/length) captured when each value was dispatched to the engines.
- Emits a filtered or annotated result stream toward the response formatter.
- Buffers metadata so that engine latency (many cycles per value) does not stall dispatch.

---
 rtl/kvs_vs_regex_pkg.sv | 31 +++
 rtl/kvs_vs_sync_fifo.sv | 55 +++++
 rtl/kvs_vs_regex_decision_join.sv | 103 ++++++++++
 tb/tb_kvs_vs_regex_decision_join.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kvs_vs_regex_pkg.sv
// Shared constants for the regex decision join: default widths and the
// layout of the per-value metadata word.
package kvs_vs_regex_pkg;

  localparam int unsigned META_WIDTH_DEF     = 96;
  localparam int unsigned FIFO_ADDR_BITS_DEF = 6;
  localparam int unsigned CNT_WIDTH_DEF      = 32;

  // Metadata field layout: key pointer [63:0], value length [79:64],
  // engine id [83:80], remaining bits reserved.
  localparam int unsigned META_KEYPTR_LSB = 0;
  localparam int unsigned META_KEYPTR_W   = 64;
  localparam int unsigned META_VLEN_LSB   = 64;
  localparam int unsigned META_VLEN_W     = 16;
  localparam int unsigned META_ENGID_LSB  = 80;
  localparam int unsigned META_ENGID_W    = 4;

  typedef struct packed {
    logic [META_WIDTH_DEF-1:84] rsvd;
    logic [META_ENGID_W-1:0]    engine_id;
    logic [META_VLEN_W-1:0]     value_len;
    logic [META_KEYPTR_W-1:0]   key_ptr;
  } meta_t;

  function automatic logic [META_ENGID_W-1:0] meta_engine_id(input logic [META_WIDTH_DEF-1:0] m);
    meta_t s;
    s = meta_t'(m);
    return s.engine_id;
  endfunction

endpackage

// File: rtl/kvs_vs_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/level outputs.
// A push while full is refused even if a pop happens in the same cycle.
module kvs_vs_sync_fifo #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [ADDR_BITS:0]   level_o
);

  localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(1) << ADDR_BITS;

  logic [WIDTH-1:0]     mem_q [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]   level_q;
  logic                 push_ok, pop_ok;

  assign full_o  = (level_q == DEPTH);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/kvs_vs_regex_decision_join.sv
// Pairs in-order regex match decisions with buffered per-value metadata and
// emits a filtered (drop mode) or annotated (forward-all mode) result stream.
module kvs_vs_regex_decision_join
  import kvs_vs_regex_pkg::*;
#(
  parameter int unsigned META_WIDTH     = META_WIDTH_DEF,
  parameter int unsigned FIFO_ADDR_BITS = FIFO_ADDR_BITS_DEF,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [META_WIDTH-1:0]     meta_data,
  input  logic                      meta_valid,
  output logic                      meta_ready,
  input  logic                      found_loc,
  input  logic                      found_valid,
  output logic                      found_ready,
  input  logic                      cfg_drop_nonmatch,
  output logic [META_WIDTH-1:0]     out_data,
  output logic                      out_match,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_WIDTH-1:0]      stat_values,
  output logic [CNT_WIDTH-1:0]      stat_matches,
  output logic [FIFO_ADDR_BITS:0]   fifo_level
);

  logic                  fifo_full, fifo_empty;
  logic [META_WIDTH-1:0] fifo_head;
  logic                  slot_free, fire, emit;

  logic [META_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_match_q, out_match_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  stat_values_q, stat_matches_q;

  // Handshakes are masked during reset so nothing is accepted in that cycle.
  assign meta_ready  = ~fifo_full & ~rst;
  assign slot_free   = ~out_valid_q | out_ready;
  assign fire        = found_valid & ~fifo_empty & slot_free & ~rst;
  assign found_ready = fire;
  assign emit        = fire & (found_loc | ~cfg_drop_nonmatch);

  kvs_vs_sync_fifo #(
    .WIDTH     (META_WIDTH),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_meta_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (meta_valid & meta_ready),
    .wdata_i (meta_data),
    .pop_i   (fire),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Output register next state: load on an emitting fire, clear on accept.
  always_comb begin
    out_data_d  = out_data_q;
    out_match_d = out_match_q;
    out_valid_d = out_valid_q;
    if (emit) begin
      out_data_d  = fifo_head;
      out_match_d = found_loc;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_match_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_match_q <= out_match_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Statistics counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_values_q  <= '0;
      stat_matches_q <= '0;
    end else if (fire) begin
      stat_values_q  <= stat_values_q + 1'b1;
      stat_matches_q <= stat_matches_q + CNT_WIDTH'(found_loc);
    end
  end

  assign out_data     = out_data_q;
  assign out_match    = out_match_q;
  assign out_valid    = out_valid_q;
  assign stat_values  = stat_values_q;
  assign stat_matches = stat_matches_q;

endmodule

// File: tb/tb_kvs_vs_regex_decision_join.sv
// Directed bench with a scoreboard: accepted decisions pair with a model
// metadata queue and push expected results; accepted outputs pop and compare.
module tb_kvs_vs_regex_decision_join;

  localparam int unsigned MW = 96;
  localparam int unsigned AB = 6;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] meta_data;
  logic          meta_valid;
  logic          meta_ready;
  logic          found_loc;
  logic          found_valid;
  logic          found_ready;
  logic          cfg_drop_nonmatch;
  logic [MW-1:0] out_data;
  logic          out_match;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] stat_values;
  logic [CW-1:0] stat_matches;
  logic [AB:0]   fifo_level;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [MW-1:0] mq[$];
  logic [MW:0]   exp_q[$];
  logic [CW-1:0] m_values, m_matches;

  kvs_vs_regex_decision_join #(
    .META_WIDTH     (MW),
    .FIFO_ADDR_BITS (AB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .meta_data         (meta_data),
    .meta_valid        (meta_valid),
    .meta_ready        (meta_ready),
    .found_loc         (found_loc),
    .found_valid       (found_valid),
    .found_ready       (found_ready),
    .cfg_drop_nonmatch (cfg_drop_nonmatch),
    .out_data          (out_data),
    .out_match         (out_match),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .stat_values       (stat_values),
    .stat_matches      (stat_matches),
    .fifo_level        (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_values  = '0;
    m_matches = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: sample handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=%0h/%0b expected=none", out_data, out_match);
        end
        if (exp_q.size() != 0) begin
          logic [MW:0] e;
          e = exp_q.pop_front();
          checks++;
          assert ({out_match, out_data} === e) else begin
            failures++;
            $error("FAIL sb_result observed=%0h/%0b expected=%0h/%0b",
                   out_data, out_match, e[MW-1:0], e[MW]);
          end
          n_out++;
        end
      end
      if (found_valid && found_ready) begin
        checks++;
        assert (mq.size() != 0) else begin
          failures++;
          $error("FAIL sb_fire_empty observed=fire expected=stall");
        end
        if (mq.size() != 0) begin
          logic [MW-1:0] h;
          h = mq.pop_front();
          m_values  = m_values + 1;
          m_matches = m_matches + CW'(found_loc);
          if (found_loc || !cfg_drop_nonmatch) exp_q.push_back({found_loc, h});
        end
      end
      if (meta_valid && meta_ready) mq.push_back(meta_data);
    end
  end

  initial begin
    logic [2:0] dec;
    int n0;
    rst = 1'b1; meta_data = '0; meta_valid = 1'b0; found_loc = 1'b0;
    found_valid = 1'b0; cfg_drop_nonmatch = 1'b0; out_ready = 1'b1;
    model_clear();
    tick(); tick();
    meta_valid = 1'b1;
    found_valid = 1'b1;
    #1;
    chk("rst_out_valid", MW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_match", MW'(out_match), '0);
    chk("rst_level", MW'(fifo_level), '0);
    chk("rst_values", MW'(stat_values), '0);
    chk("rst_matches", MW'(stat_matches), '0);
    chk("rst_meta_ready", MW'(meta_ready), '0);
    chk("rst_found_ready", MW'(found_ready), '0);
    meta_valid = 1'b0; found_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Forward-all mode.
    dec = 3'b101;
    for (int i = 1; i <= 3; i++) begin
      meta_valid = 1'b1; meta_data = MW'(i); tick();
    end
    meta_valid = 1'b0;
    #1 chk("fwd_level", MW'(fifo_level), 3);
    for (int i = 0; i < 3; i++) begin
      found_valid = 1'b1; found_loc = dec[i];
      #1 chk("fwd_found_ready", MW'(found_ready), 1);
      tick();
      if (i > 0) begin
        chk("fwd_consec_valid", MW'(out_valid), 1);
        chk("fwd_consec_data", out_data, MW'(i + 1));
      end
    end
    found_valid = 1'b0;
    tick(); tick();
    chk("fwd_values", MW'(stat_values), 3);
    chk("fwd_matches", MW'(stat_matches), 2);
    chk("fwd_sb_empty", MW'(exp_q.size()), 0);

    // Drop mode.
    do_reset();
    cfg_drop_nonmatch = 1'b1;
    n0 = n_out;
    for (int i = 1; i <= 3; i++) begin
      meta_valid = 1'b1; meta_data = MW'(i); tick();
    end
    meta_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      found_valid = 1'b1; found_loc = dec[i]; tick();
    end
    found_valid = 1'b0;
    tick(); tick();
    chk("drop_emitted", MW'(n_out - n0), 2);
    chk("drop_values", MW'(stat_values), 3);
    chk("drop_matches", MW'(stat_matches), 2);
    chk("drop_level", MW'(fifo_level), 0);
    cfg_drop_nonmatch = 1'b0;

    // Decision before metadata.
    do_reset();
    found_valid = 1'b1; found_loc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("early_found_ready", MW'(found_ready), 0);
      tick();
    end
    meta_valid = 1'b1; meta_data = MW'('hA);
    #1 chk("early_push_cycle", MW'(found_ready), 0);
    tick();
    meta_valid = 1'b0;
    #1 chk("early_after_push", MW'(found_ready), 1);
    tick();
    found_valid = 1'b0;
    chk("early_out_valid", MW'(out_valid), 1);
    chk("early_out_data", out_data, MW'('hA));
    chk("early_out_match", MW'(out_match), 1);
    tick();

    // Full FIFO, then refused push during a pop.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      meta_valid = 1'b1; meta_data = MW'(32'h100 + i); tick();
    end
    meta_valid = 1'b0;
    #1;
    chk("full_meta_ready", MW'(meta_ready), 0);
    chk("full_level", MW'(fifo_level), 64);
    meta_valid = 1'b1; meta_data = MW'('hDEAD);
    found_valid = 1'b1; found_loc = 1'b1;
    #1;
    chk("full_push_refused", MW'(meta_ready), 0);
    chk("full_pop_fires", MW'(found_ready), 1);
    tick();
    meta_valid = 1'b0; found_valid = 1'b0;
    #1;
    chk("full_level_after", MW'(fifo_level), 63);
    chk("full_ready_back", MW'(meta_ready), 1);
    for (int i = 0; i < 63; i++) begin
      found_valid = 1'b1; found_loc = 1'($urandom_range(0, 1)); tick();
    end
    found_valid = 1'b0;
    tick(); tick();
    chk("full_drain_sb", MW'(exp_q.size()), 0);
    chk("full_drain_level", MW'(fifo_level), 0);
    chk("full_values", stat_values, MW'(m_values));
    chk("full_matches", stat_matches, MW'(m_matches));

    // Backpressure.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      meta_valid = 1'b1; meta_data = MW'(32'h50 + i); tick();
    end
    meta_valid = 1'b0;
    found_valid = 1'b1; found_loc = 1'b1;
    #1 chk("bp_first_fire", MW'(found_ready), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", MW'(out_valid), 1);
      chk("bp_hold_data", out_data, MW'('h50));
      chk("bp_stall", MW'(found_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_fire", MW'(found_ready), 1);
    tick(); tick(); tick();
    found_valid = 1'b0;
    tick(); tick();
    chk("bp_sb_empty", MW'(exp_q.size()), 0);
    chk("bp_values", MW'(stat_values), 4);

    // Reset mid-stream.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      meta_valid = 1'b1; meta_data = MW'(32'h60 + i); tick();
    end
    meta_valid = 1'b0;
    found_valid = 1'b1; found_loc = 1'b1; tick();
    found_valid = 1'b0;
    chk("mid_pre_valid", MW'(out_valid), 1);
    chk("mid_pre_level", MW'(fifo_level), 5);
    do_reset();
    chk("mid_out_valid", MW'(out_valid), 0);
    chk("mid_level", MW'(fifo_level), 0);
    chk("mid_values", MW'(stat_values), 0);
    chk("mid_matches", MW'(stat_matches), 0);
    out_ready = 1'b1;
    meta_valid = 1'b1; meta_data = MW'('h7); tick();
    meta_valid = 1'b0;
    found_valid = 1'b1; found_loc = 1'b1;
    #1 chk("mid_fire", MW'(found_ready), 1);
    tick();
    found_valid = 1'b0;
    chk("mid_out_data", out_data, MW'('h7));
    chk("mid_out_match", MW'(out_match), 1);
    tick(); tick();
    chk("mid_sb_empty", MW'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
